// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for branch resolution: branch opcodes and controller state encodings.
// Imported by the controller, its comparator and the pipeline-facing interface.
package branch_resolve_ctrl_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OPCODE_BNE = 4'h0;
    localparam opcode_t OPCODE_BEQ = 4'h1;
    localparam opcode_t OPCODE_BGZ = 4'h2;
    localparam opcode_t OPCODE_BLZ = 4'h3;

    typedef enum logic [1:0] {
        BR_IDLE      = 2'd0,
        BR_WAIT_OPND = 2'd1,
        BR_EVAL      = 2'd2,
        BR_REDIRECT  = 2'd3
    } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Branch request / resolve / redirect bundle between the ID/EX pipeline and the controller.
// master = pipeline side, slave = branch_resolve_ctrl.
interface branch_resolve_ctrl_if #(
    parameter int WORD_SIZE = 16,
    parameter int IMM_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    import branch_resolve_ctrl_pkg::*;

    logic                  br_valid;
    logic                  br_ready;
    opcode_t               br_opcode;
    logic [WORD_SIZE-1:0]  br_pc;
    logic [IMM_WIDTH-1:0]  br_imm;
    logic                  br_pred_taken;
    logic [WORD_SIZE-1:0]  rs_data;
    logic [WORD_SIZE-1:0]  rt_data;
    logic                  operands_ready;
    logic                  kill;
    logic                  br_stall;
    logic                  resolve_valid;
    logic                  resolve_taken;
    logic                  redirect_valid;
    logic [WORD_SIZE-1:0]  redirect_pc;
    logic                  redirect_ack;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  branch_count;
    logic [CNT_WIDTH-1:0]  mispredict_count;

    modport master (
        output br_valid, br_opcode, br_pc, br_imm, br_pred_taken,
               rs_data, rt_data, operands_ready, kill, redirect_ack,
        input  br_ready, br_stall, resolve_valid, resolve_taken,
               redirect_valid, redirect_pc, flush, branch_count, mispredict_count
    );

    modport slave (
        input  br_valid, br_opcode, br_pc, br_imm, br_pred_taken,
               rs_data, rt_data, operands_ready, kill, redirect_ack,
        output br_ready, br_stall, resolve_valid, resolve_taken,
               redirect_valid, redirect_pc, flush, branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_resolve_ctrl_cmp.sv
// Shared branch comparator: evaluates the branch condition for one opcode/operand pair.
// Purely combinational, zero latency, no handshake.
module branch_resolve_ctrl_cmp
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  opcode_t              opcode,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 bcond
);

    always_comb begin
        bcond = 1'b0;
        case (opcode)
            OPCODE_BNE: bcond = (a != b);
            OPCODE_BEQ: bcond = (a == b);
            OPCODE_BGZ: bcond = ($signed(a) > 0);
            OPCODE_BLZ: bcond = ($signed(a) < 0);
            default:    bcond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accept, wait for operands, evaluate, redirect on mispredict.
// Resolve one cycle after operands latch, redirect the cycle after; br_ready only in IDLE, redirect held until ack.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IMM_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_resolve_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    br_state_e             state_q, state_d;
    opcode_t               opc_q, opc_d;
    logic [WORD_SIZE-1:0]  pc_q, pc_d;
    logic [IMM_WIDTH-1:0]  imm_q, imm_d;
    logic                  pred_q, pred_d;
    logic [WORD_SIZE-1:0]  a_q, a_d;
    logic [WORD_SIZE-1:0]  b_q, b_d;
    logic [WORD_SIZE-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0]  mp_cnt_q, mp_cnt_d;

    logic                  bcond;
    logic [WORD_SIZE-1:0]  pc_plus1;
    logic [WORD_SIZE-1:0]  target;

    branch_resolve_ctrl_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp (
        .opcode (opc_q),
        .a      (a_q),
        .b      (b_q),
        .bcond  (bcond)
    );

    assign pc_plus1 = pc_q + WORD_SIZE'(1);
    assign target   = pc_plus1 + {{(WORD_SIZE-IMM_WIDTH){imm_q[IMM_WIDTH-1]}}, imm_q};

    always_comb begin
        state_d       = state_q;
        opc_d         = opc_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        pred_d        = pred_q;
        a_d           = a_q;
        b_d           = b_q;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mp_cnt_d      = mp_cnt_q;

        case (state_q)
            BR_IDLE: begin
                // kill in IDLE suppresses acceptance; the requester keeps br_valid up
                if (bus.br_valid && !bus.kill) begin
                    opc_d  = bus.br_opcode;
                    pc_d   = bus.br_pc;
                    imm_d  = bus.br_imm;
                    pred_d = bus.br_pred_taken;
                    if (bus.operands_ready) begin
                        a_d     = bus.rs_data;
                        b_d     = bus.rt_data;
                        state_d = BR_EVAL;
                    end else begin
                        state_d = BR_WAIT_OPND;
                    end
                end
            end
            BR_WAIT_OPND: begin
                if (bus.kill) begin
                    state_d = BR_IDLE;
                end else if (bus.operands_ready) begin
                    a_d     = bus.rs_data;
                    b_d     = bus.rt_data;
                    state_d = BR_EVAL;
                end
            end
            BR_EVAL: begin
                if (bus.kill) begin
                    state_d = BR_IDLE;
                end else begin
                    redirect_pc_d = bcond ? target : pc_plus1;
                    if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
                    if (bcond != pred_q) begin
                        if (mp_cnt_q != CNT_MAX) mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
                        state_d = BR_REDIRECT;
                    end else begin
                        state_d = BR_IDLE;
                    end
                end
            end
            BR_REDIRECT: begin
                if (bus.kill || bus.redirect_ack) state_d = BR_IDLE;
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= BR_IDLE;
            opc_q         <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            pred_q        <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mp_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            opc_q         <= opc_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            pred_q        <= pred_d;
            a_q           <= a_d;
            b_q           <= b_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mp_cnt_q      <= mp_cnt_d;
        end
    end

    assign bus.br_ready         = (state_q == BR_IDLE);
    assign bus.br_stall         = (state_q != BR_IDLE);
    assign bus.resolve_valid    = (state_q == BR_EVAL) && !bus.kill;
    assign bus.resolve_taken    = (state_q == BR_EVAL) && bcond;
    assign bus.redirect_valid   = (state_q == BR_REDIRECT) && !bus.kill;
    assign bus.flush            = bus.redirect_valid;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = br_cnt_q;
    assign bus.mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed cases then randomized branches against a transaction-level model.
// Counters are narrowed to 8 bits so saturation is reachable in a short run.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    localparam int WS = 16;
    localparam int IW = 8;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic reset_n;

    int n_cmp = 0;
    int n_err = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_resolve_ctrl_if #(.WORD_SIZE(WS), .IMM_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    branch_resolve_ctrl #(.WORD_SIZE(WS), .IMM_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua;
        ua = int'(a);
        if (op == OPCODE_BNE) return a != b;
        if (op == OPCODE_BEQ) return a == b;
        if (op == OPCODE_BGZ) return (ua != 0) && (ua < 32768);
        if (op == OPCODE_BLZ) return ua >= 32768;
        return 1'b0;
    endfunction

    function automatic logic [15:0] ref_target(input logic [15:0] pc, input logic [7:0] imm, input bit t);
        int off;
        int s;
        off = int'(imm);
        if (off > 127) off = off - 256;
        s = int'(pc) + 1 + (t ? off : 0);
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_brcnt"}, 32'(bus.branch_count), exp_br);
        chk({tag, "_mpcnt"}, 32'(bus.mispredict_count), exp_mp);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    // kill_mode: 0 none, 1 kill during evaluation, 2 kill during redirect.
    task automatic run_branch(input logic [3:0] op, input logic [15:0] pc, input logic [7:0] imm,
                              input logic [15:0] a, input logic [15:0] b, input bit pred,
                              input int nwait, input int kill_mode, input int ack_delay);
        bit          exp_t;
        bit          misp;
        logic [15:0] exp_pc;
        exp_t  = ref_taken(op, a, b);
        exp_pc = ref_target(pc, imm, exp_t);
        misp   = (exp_t != pred);

        bus.br_valid       = 1'b1;
        bus.br_opcode      = op;
        bus.br_pc          = pc;
        bus.br_imm         = imm;
        bus.br_pred_taken  = pred;
        bus.operands_ready = (nwait == 0);
        bus.rs_data        = (nwait == 0) ? a : 16'($urandom);
        bus.rt_data        = (nwait == 0) ? b : 16'($urandom);
        bus.kill           = 1'b0;
        bus.redirect_ack   = 1'b0;
        @(negedge clk);
        chk("idle_ready", bus.br_ready, 1);
        chk("idle_stall", bus.br_stall, 0);
        chk("idle_redir", bus.redirect_valid, 0);
        check_counters("idle");
        tick();

        bus.br_valid      = 1'b0;
        bus.br_opcode     = 4'($urandom);
        bus.br_pc         = 16'($urandom);
        bus.br_imm        = 8'($urandom);
        bus.br_pred_taken = 1'($urandom);
        for (int w = 1; w <= nwait; w++) begin
            bus.operands_ready = (w == nwait);
            bus.rs_data        = (w == nwait) ? a : 16'($urandom);
            bus.rt_data        = (w == nwait) ? b : 16'($urandom);
            @(negedge clk);
            chk("wait_stall", bus.br_stall, 1);
            chk("wait_ready", bus.br_ready, 0);
            chk("wait_rv", bus.resolve_valid, 0);
            tick();
        end

        bus.operands_ready = 1'b0;
        bus.rs_data        = 16'($urandom);
        bus.rt_data        = 16'($urandom);
        bus.kill           = (kill_mode == 1);
        @(negedge clk);
        chk("eval_rv", bus.resolve_valid, (kill_mode != 1));
        if (kill_mode != 1) chk("eval_taken", bus.resolve_taken, exp_t);
        chk("eval_stall", bus.br_stall, 1);
        chk("eval_ready", bus.br_ready, 0);
        chk("eval_redir", bus.redirect_valid, 0);
        tick();
        bus.kill = 1'b0;
        if (kill_mode == 1) return;

        if (exp_br < CNT_MAX) exp_br++;
        if (misp && exp_mp < CNT_MAX) exp_mp++;

        if (misp) begin
            for (int d = 0; d <= ack_delay; d++) begin
                bus.redirect_ack = (d == ack_delay) && (kill_mode != 2);
                bus.kill         = (d == ack_delay) && (kill_mode == 2);
                @(negedge clk);
                if (bus.kill) begin
                    chk("kill_redir_rv", bus.redirect_valid, 0);
                    chk("kill_redir_flush", bus.flush, 0);
                end else begin
                    chk("redir_vld", bus.redirect_valid, 1);
                    chk("redir_flush", bus.flush, 1);
                    chk("redir_pc", bus.redirect_pc, exp_pc);
                end
                chk("redir_ready", bus.br_ready, 0);
                chk("redir_stall", bus.br_stall, 1);
                tick();
            end
            bus.redirect_ack = 1'b0;
            bus.kill         = 1'b0;
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          km;
        int          sel;

        reset_n            = 1'b0;
        bus.br_valid       = 1'b0;
        bus.br_opcode      = '0;
        bus.br_pc          = '0;
        bus.br_imm         = '0;
        bus.br_pred_taken  = 1'b0;
        bus.rs_data        = '0;
        bus.rt_data        = '0;
        bus.operands_ready = 1'b0;
        bus.kill           = 1'b0;
        bus.redirect_ack   = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", bus.br_ready, 1);
        chk("rst_stall", bus.br_stall, 0);
        chk("rst_rv", bus.resolve_valid, 0);
        chk("rst_taken", bus.resolve_taken, 0);
        chk("rst_redir", bus.redirect_valid, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_rpc", bus.redirect_pc, 0);
        check_counters("rst");
        tick();
        reset_n = 1'b1;

        run_branch(OPCODE_BEQ, 16'h0010, 8'h05, 16'h1234, 16'h1234, 1'b0, 0, 0, 2);
        run_branch(OPCODE_BGZ, 16'h0020, 8'h10, 16'h8000, 16'h0000, 1'b0, 0, 0, 0);
        run_branch(OPCODE_BLZ, 16'h0100, 8'hFE, 16'hFFFF, 16'h0000, 1'b1, 3, 0, 0);
        run_branch(OPCODE_BLZ, 16'h0100, 8'hFE, 16'hFFFF, 16'h0000, 1'b0, 3, 0, 1);
        run_branch(OPCODE_BNE, 16'hFFFF, 8'h22, 16'h0001, 16'h0001, 1'b1, 0, 0, 0);
        run_branch(OPCODE_BEQ, 16'h0040, 8'h80, 16'h0007, 16'h0007, 1'b0, 1, 1, 0);
        run_branch(OPCODE_BEQ, 16'h0050, 8'h7F, 16'h0003, 16'h0003, 1'b0, 0, 2, 1);

        // kill while idle must block acceptance
        bus.br_valid       = 1'b1;
        bus.br_opcode      = OPCODE_BEQ;
        bus.operands_ready = 1'b1;
        bus.kill           = 1'b1;
        tick();
        bus.br_valid = 1'b0;
        bus.kill     = 1'b0;
        @(negedge clk);
        chk("idle_kill_ready", bus.br_ready, 1);
        chk("idle_kill_stall", bus.br_stall, 0);
        tick();

        // reset in the middle of an operand wait
        bus.br_valid       = 1'b1;
        bus.br_opcode      = OPCODE_BNE;
        bus.operands_ready = 1'b0;
        tick();
        bus.br_valid = 1'b0;
        @(negedge clk);
        chk("wait_pre_rst_stall", bus.br_stall, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_br  = 0;
        exp_mp  = 0;
        @(negedge clk);
        chk("mid_rst_ready", bus.br_ready, 1);
        chk("mid_rst_stall", bus.br_stall, 0);
        chk("mid_rst_redir", bus.redirect_valid, 0);
        check_counters("mid_rst");
        tick();

        for (int i = 0; i < 300; i++) begin
            op  = 4'($urandom_range(0, 5));
            sel = $urandom_range(0, 5);
            case (sel)
                0: a = 16'h0000;
                1: a = 16'h0001;
                2: a = 16'h7FFF;
                3: a = 16'h8000;
                4: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            b  = ($urandom_range(0, 2) == 0) ? a : 16'($urandom);
            sel = $urandom_range(0, 9);
            km = (sel == 0) ? 1 : ((sel == 1) ? 2 : 0);
            run_branch(op, 16'($urandom), 8'($urandom), a, b, 1'($urandom),
                       ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), km, $urandom_range(0, 2));
        end

        // drive every branch as a mispredict until both counters pin at all-ones
        for (int i = 0; i < 270; i++) begin
            op = 4'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 1) == 0) ? a : 16'($urandom);
            run_branch(op, 16'($urandom), 8'($urandom), a, b, !ref_taken(op, a, b), 0, 0, 0);
        end

        @(negedge clk);
        chk("final_ready", bus.br_ready, 1);
        chk("final_brcnt_sat", 32'(bus.branch_count), CNT_MAX);
        chk("final_mpcnt_sat", 32'(bus.mispredict_count), CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the 16-bit pipelined CPU.
- Accepts one conditional branch at a time from the ID/EX boundary and waits until forwarded operands are ready.
- Drives the shared branch comparator, compares the outcome with the fetch-stage prediction, and issues a flush/redirect handshake on mispredict.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
WORD_SIZE, 16, datapath/operand/PC width
IMM_WIDTH, 8, branch offset field width, sign-extended
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
br_valid  input  1  branch request present; held with fields stable until accepted
br_ready  output  1  controller can accept a request (state IDLE)
br_opcode  input  4  opcode of branch instruction (BNE/BEQ/BGZ/BLZ)
br_pc  input  WORD_SIZE  PC of branch instruction
br_imm  input  IMM_WIDTH  signed branch offset
br_pred_taken  input  1  prediction used by fetch for this branch
rs_data  input  WORD_SIZE  first operand (forwarded)
rt_data  input  WORD_SIZE  second operand (forwarded)
operands_ready  input  1  rs_data/rt_data valid this cycle
kill  input  1  higher-priority pipeline flush (exception/jump in later stage)
br_stall  output  1  stall ID and earlier stages
resolve_valid  output  1  one-cycle pulse, branch outcome known
resolve_taken  output  1  actual outcome, valid with resolve_valid
redirect_valid  output  1  mispredict redirect request, held until ack
redirect_pc  output  WORD_SIZE  correct next PC, stable while redirect_valid
redirect_ack  input  1  fetch accepted redirect
flush  output  1  squash younger instructions, equals redirect_valid
branch_count  output  CNT_WIDTH  branches resolved, saturating
mispredict_count  output  CNT_WIDTH  mispredicts, saturating

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE. All outputs 0, except br_ready=1. Both counters 0. Internal registers cleared. Reset in any state aborts the in-flight branch with no redirect.
- States: IDLE, WAIT_OPND, EVAL, REDIRECT. Encodings are 2-bit and live in the shared header.
- IDLE: br_ready=1, br_stall=0. On br_valid, latch opcode, pc, imm and pred.
  - If operands_ready is also 1: latch rs_data/rt_data and go to EVAL.
  - Otherwise go to WAIT_OPND.
- WAIT_OPND: br_stall=1, br_ready=0. When operands_ready=1, latch operands and go to EVAL.
- EVAL, exactly one cycle: br_stall=1.
  - resolve_valid=1; resolve_taken = comparator bcond on the latched A/B/opcode.
  - Comparator semantics: BNE A!=B; BEQ A==B; BGZ A>0 signed; BLZ A<0 signed. Any other opcode resolves not-taken.
  - branch_count increments.
  - Mispredict when resolve_taken != latched pred. On mispredict, mispredict_count increments and the state goes to REDIRECT; otherwise it goes to IDLE.
  - redirect_pc is registered here: taken gives pc+1+sext(imm); not-taken gives pc+1. Arithmetic is modulo 2^WORD_SIZE (0xFFFF+1 = 0x0000).
- REDIRECT: redirect_valid=1, flush=1, br_stall=1, redirect_pc held. On redirect_ack, go to IDLE next cycle.
- Latency: request accepted with ready operands at cycle 0 → resolve_valid at cycle 1 → redirect_valid from cycle 2 if mispredicted.
- Back-to-back: the next request is accepted in the cycle after returning to IDLE. br_ready is never combinationally asserted in EVAL or REDIRECT.
- kill:
  - Highest priority after reset. In WAIT_OPND, EVAL or REDIRECT, the next state is IDLE and resolve_valid/redirect_valid are forced 0 in that cycle.
  - Counters do not increment in a killed EVAL cycle.
  - kill in IDLE blocks acceptance that cycle.
- Counters saturate at all-ones and do not wrap.
- Outputs are registered or decoded from state/latched registers only. There is no combinational path from rs_data/rt_data to any output.

Decomposition:
- The shared opcodes.v supplies OPCODE_BNE/BEQ/BGZ/BLZ.
- A new shared header branch_ctrl_defs.v holds the state encodings (BR_IDLE, BR_WAIT_OPND, BR_EVAL, BR_REDIRECT).
- Instantiate the existing comparator sub-module once on the latched operands/opcode; do not duplicate its logic.
- Target adder and counters stay inline.

Test Plan:
- BEQ, pc=0x0010, imm=0x05, rs=rt=0x1234, ready, pred=0 → cycle 1 resolve_valid=1, taken=1; cycle 2 redirect_valid=1, redirect_pc=0x0016, flush=1 until ack; mispredict_count=1.
- BGZ, rs=0x8000, pred=0, ready → resolve taken=0, no redirect; back in IDLE at cycle 2; branch_count=1, mispredict_count=0.
- BLZ, pc=0x0100, imm=0xFE, rs=0xFFFF, pred=1, operands_ready low for 3 cycles → br_stall=1 for WAIT×3+EVAL; taken=1, no redirect. Separately, same with pred=0 → redirect_pc=0x00FF.
- BNE, pc=0xFFFF, rs=1, rt=1, pred=1 → taken=0, redirect_pc=0x0000 (wrap).
- kill asserted in REDIRECT, and separately in EVAL → next cycle IDLE, redirect_valid=0; killed EVAL leaves counters unchanged.
- Preload via 65535 mispredicts (or force) → further mispredict keeps mispredict_count=0xFFFF. reset_n=0 mid-WAIT_OPND → next cycle IDLE, br_ready=1, counters 0.
